// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing and 160x120 framebuffer constants, used by
// the scanout and by the clear/draw writers.
package vga_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;   // 800

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;   // 525

  localparam int FB_W    = 160;
  localparam int FB_H    = 120;
  localparam int COLOR_W = 3;
  localparam int ADDR_W  = 15;
  localparam int CNT_W   = 10;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [ADDR_W-1:0]  fb_addr_t;
  typedef logic [COLOR_W-1:0] color_t;

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t HS_START = cnt_t'(H_VIS + H_FP);
  localparam cnt_t HS_END   = cnt_t'(H_VIS + H_FP + H_SYNC);
  localparam cnt_t VS_START = cnt_t'(V_VIS + V_FP);
  localparam cnt_t VS_END   = cnt_t'(V_VIS + V_FP + V_SYNC);

  // Per-pixel control bits that travel down the alignment pipeline.
  typedef struct packed {
    logic vis;
    logic hsync_n;
    logic vsync_n;
  } vid_ctl_t;

  localparam vid_ctl_t CTL_IDLE = '{vis: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1};

  // Cell address for a screen pixel: (y>>2)*160 + (x>>2), 160 = 128 + 32 so
  // two shifts and adds replace the multiplier.
  function automatic fb_addr_t cell_addr(input cnt_t h, input cnt_t v);
    fb_addr_t fx;
    fb_addr_t fy;
    fx = fb_addr_t'(h >> 2);
    fy = fb_addr_t'(v >> 2);
    return (fy << 7) + (fy << 5) + fx;
  endfunction

endpackage

// File: rtl/vga_fb_scanout_if.sv
// Framebuffer read port: registered address out, synchronous read data back.
interface vga_fb_scanout_if;
  import vga_pkg::*;

  fb_addr_t rd_addr;
  color_t   rd_data;

  modport master (output rd_addr, input  rd_data);
  modport slave  (input  rd_addr, output rd_data);
endinterface

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical counters and stage-0 decode: visible window, raw
// active-low syncs and the end-of-frame wrap flag.
module vga_timing_gen
  import vga_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     pix_en,
  output cnt_t     h_cnt,
  output cnt_t     v_cnt,
  output vid_ctl_t ctl,
  output logic     frame_wrap
);

  // Raster counters: h wraps at 799, v steps on each h wrap and wraps at 524.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + cnt_t'(1);
      end else begin
        h_cnt <= h_cnt + cnt_t'(1);
      end
    end
  end

  // Decode of the current counter position.
  always_comb begin
    ctl         = CTL_IDLE;
    ctl.vis     = (h_cnt < cnt_t'(H_VIS)) && (v_cnt < cnt_t'(V_VIS));
    ctl.hsync_n = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    ctl.vsync_n = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    frame_wrap  = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  end

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer scanout: counters -> read address (stage 1) -> colour and
// syncs on the pins (stage 2), all advancing on pix_en ticks only.
module vga_fb_scanout
  import vga_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pix_en,
  vga_fb_scanout_if.master        fb,
  output color_t                  vga_rgb,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic                    vga_blank_n,
  output logic                    frame_start
);

  cnt_t     h_cnt;
  cnt_t     v_cnt;
  vid_ctl_t ctl_s0;
  vid_ctl_t ctl_s1;
  logic     frame_wrap;

  vga_timing_gen u_tg (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .ctl        (ctl_s0),
    .frame_wrap (frame_wrap)
  );

  // Stage 1: issue the cell address for visible pixels (held in blanking so
  // the RAM is not toggled needlessly) and delay control bits alongside.
  always_ff @(posedge clk) begin
    if (reset) begin
      fb.rd_addr <= '0;
      ctl_s1     <= CTL_IDLE;
    end else if (pix_en) begin
      if (ctl_s0.vis) fb.rd_addr <= cell_addr(h_cnt, v_cnt);
      ctl_s1 <= ctl_s0;
    end
  end

  // Stage 2: RAM data for the stage-1 address has landed by the next tick;
  // gate it with the delayed visible bit and register syncs to match.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_rgb     <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_blank_n <= 1'b0;
    end else if (pix_en) begin
      vga_rgb     <= ctl_s1.vis ? fb.rd_data : '0;
      vga_hsync   <= ctl_s1.hsync_n;
      vga_vsync   <= ctl_s1.vsync_n;
      vga_blank_n <= ctl_s1.vis;
    end
  end

  // One-clk pulse on the tick where the counters wrap (799,524) -> (0,0).
  always_ff @(posedge clk) begin
    if (reset) frame_start <= 1'b0;
    else       frame_start <= pix_en & frame_wrap;
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout: table of pixel positions with
// hand-computed address/colour/sync values plus reset, line-timing and stall
// sequences. RAM model returns rd_addr[2:0] (or 3'b111 when ram_ones is set).
module tb_vga_fb_scanout;

  logic clk = 1'b0;
  logic reset;
  logic pix_en;
  logic [2:0] vga_rgb;
  logic vga_hsync, vga_vsync, vga_blank_n, frame_start;
  logic ram_ones;

  int nvec  = 0;
  int nfail = 0;
  int fs_count = 0;
  int cur_h = 0;
  int cur_v = 0;
  int jump_val = 0;

  localparam int BUDGET = 20000;

  vga_fb_scanout_if fb_if();

  vga_fb_scanout dut (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .fb          (fb_if),
    .vga_rgb     (vga_rgb),
    .vga_hsync   (vga_hsync),
    .vga_vsync   (vga_vsync),
    .vga_blank_n (vga_blank_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model.
  always @(posedge clk) fb_if.rd_data <= ram_ones ? 3'b111 : fb_if.rd_addr[2:0];

  always @(negedge clk) if (frame_start) fs_count++;

  typedef struct {
    int jv; bit ones; int h; int v;
    int addr; int rgb; bit hs; bit vs; bit bn; bit fs;
  } vec_t;

  vec_t tv[21];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (h=%0d v=%0d)", nm, act, exp, cur_h, cur_v);
    end
  endtask

  // One pix_en tick: enable high across one posedge, low across the next.
  // Returns on the negedge right after the tick edge (sample point).
  task automatic do_tick();
    @(negedge clk) pix_en = 1'b1;
    @(negedge clk) pix_en = 1'b0;
    if (cur_h == 799) begin
      cur_h = 0;
      cur_v = (cur_v == 524) ? 0 : cur_v + 1;
    end else begin
      cur_h++;
    end
  endtask

  // Run until the tick that processes counter position (h,v) has happened.
  task automatic advance_to(input int h, input int v);
    int n = 0;
    while (!(cur_h == h && cur_v == v) && n < BUDGET) begin
      do_tick();
      n++;
    end
    if (n >= BUDGET) begin
      nvec++; nfail++;
      $display("FAIL advance_budget: got %0d ticks expected < %0d", n, BUDGET);
    end
    do_tick();
  endtask

  // Skip ahead to line nv at the next line start by overriding v_cnt.
  task automatic jump_to(input int nv);
    int n = 0;
    while (cur_h != 0 && n < 800) begin
      do_tick();
      n++;
    end
    jump_val = nv;
    force dut.u_tg.v_cnt = 10'(jump_val);
    #1;
    release dut.u_tg.v_cnt;
    cur_v = nv;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_addr"}, int'(fb_if.rd_addr), 0);
    chk({tag, "_rgb"},     int'(vga_rgb), 0);
    chk({tag, "_hsync"},   int'(vga_hsync), 1);
    chk({tag, "_vsync"},   int'(vga_vsync), 1);
    chk({tag, "_blank_n"}, int'(vga_blank_n), 0);
    chk({tag, "_fstart"},  int'(frame_start), 0);
  endtask

  initial begin
    int hs_low, hs_first, bn_cnt;
    //          jv  ones h    v    addr   rgb hs vs bn fs
    tv[0]  = '{-1, 0,   3,   3,   0,     0,  1, 1, 1, 0};
    tv[1]  = '{-1, 0,   5,   3,   1,     1,  1, 1, 1, 0};
    tv[2]  = '{-1, 0,   30,  3,   7,     7,  1, 1, 1, 0};
    tv[3]  = '{-1, 0,   638, 3,   159,   7,  1, 1, 1, 0};
    tv[4]  = '{-1, 1,   645, 3,   159,   0,  1, 1, 0, 0};
    tv[5]  = '{-1, 1,   700, 3,   159,   0,  0, 1, 0, 0};
    tv[6]  = '{-1, 0,   0,   4,   160,   0,  1, 1, 1, 0};
    tv[7]  = '{-1, 0,   4,   4,   161,   1,  1, 1, 1, 0};
    tv[8]  = '{-1, 0,   100, 9,   345,   1,  1, 1, 1, 0};
    tv[9]  = '{-1, 0,   751, 9,   479,   0,  0, 1, 0, 0};
    tv[10] = '{-1, 0,   753, 9,   479,   0,  1, 1, 0, 0};
    tv[11] = '{478, 0,  0,   478, 19040, 0,  1, 1, 1, 0};
    tv[12] = '{-1, 0,   639, 479, 19199, 7,  1, 1, 1, 0};
    tv[13] = '{-1, 1,   654, 479, 19199, 0,  1, 1, 0, 0};
    tv[14] = '{-1, 1,   656, 479, 19199, 0,  0, 1, 0, 0};
    tv[15] = '{-1, 0,   0,   480, 19199, 0,  1, 1, 0, 0};
    tv[16] = '{-1, 0,   0,   490, 19199, 0,  1, 0, 0, 0};
    tv[17] = '{-1, 0,   700, 491, 19199, 0,  0, 0, 0, 0};
    tv[18] = '{-1, 0,   10,  492, 19199, 0,  1, 1, 0, 0};
    tv[19] = '{523, 0,  799, 524, 19199, 0,  1, 1, 0, 1};
    tv[20] = '{-1, 0,   2,   0,   0,     0,  1, 1, 1, 0};

    // Power-on reset.
    reset = 1'b1; pix_en = 1'b0; ram_ones = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("por");

    // Run into the line, then reset for 3 clk mid-line with pix_en high.
    advance_to(100, 0);
    chk("pre_reset_addr", int'(fb_if.rd_addr), 25);
    @(negedge clk) begin reset = 1'b1; pix_en = 1'b1; end
    repeat (3) @(negedge clk);
    reset = 1'b0; pix_en = 1'b0;
    cur_h = 0; cur_v = 0;
    chk_reset_vals("midline");

    // Line 0 from the restart: after tick k the pins show pixel k-1.
    hs_low = 0; hs_first = -1; bn_cnt = 0;
    for (int k = 0; k <= 800; k++) begin
      do_tick();
      if (k == 3) chk("addr_px3", int'(fb_if.rd_addr), 0);
      if (k == 4) chk("addr_px4", int'(fb_if.rd_addr), 1);
      if (k == 5) chk("rgb_px4", int'(vga_rgb), 1);
      if (k >= 1) begin
        if (!vga_hsync) begin
          hs_low++;
          if (hs_first < 0) hs_first = k;
        end
        if (vga_blank_n) bn_cnt++;
      end
    end
    chk("hsync_low_ticks", hs_low, 96);
    chk("hsync_first_tick", hs_first, 657);
    chk("blank_n_ticks", bn_cnt, 640);
    do_tick();
    chk("line1_px0_blank_n", int'(vga_blank_n), 1);

    // Table vectors.
    for (int i = 0; i < 21; i++) begin
      ram_ones = tv[i].ones;
      if (tv[i].jv >= 0) jump_to(tv[i].jv);
      advance_to(tv[i].h, tv[i].v);
      chk($sformatf("v%0d_rd_addr", i), int'(fb_if.rd_addr), tv[i].addr);
      chk($sformatf("v%0d_fstart", i),  int'(frame_start), int'(tv[i].fs));
      do_tick();
      chk($sformatf("v%0d_rgb", i),     int'(vga_rgb), tv[i].rgb);
      chk($sformatf("v%0d_hsync", i),   int'(vga_hsync), int'(tv[i].hs));
      chk($sformatf("v%0d_vsync", i),   int'(vga_vsync), int'(tv[i].vs));
      chk($sformatf("v%0d_blank_n", i), int'(vga_blank_n), int'(tv[i].bn));
    end
    ram_ones = 1'b0;

    // Stall 10 clk mid-line in the new frame, then resume.
    advance_to(200, 0);
    chk("pre_stall_addr", int'(fb_if.rd_addr), 50);
    chk("pre_stall_rgb", int'(vga_rgb), 1);
    repeat (10) @(negedge clk);
    chk("stall_addr", int'(fb_if.rd_addr), 50);
    chk("stall_rgb", int'(vga_rgb), 1);
    chk("stall_blank_n", int'(vga_blank_n), 1);
    chk("stall_hsync", int'(vga_hsync), 1);
    do_tick();
    chk("resume_px200_rgb", int'(vga_rgb), 2);
    advance_to(204, 0);
    chk("resume_px204_addr", int'(fb_if.rd_addr), 51);
    chk("resume_px203_rgb", int'(vga_rgb), 2);
    do_tick();
    chk("resume_px204_rgb", int'(vga_rgb), 3);

    // Exactly one single-clk frame_start pulse over the whole run.
    chk("frame_start_count", fs_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
